// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side monitor for the on-chip VGA stream.
// Registers the sync/colour inputs, locks a horizontal and vertical position
// counter onto the sync edges, and presents each sample one clock later with
// its coordinates, a visible-pixel flag and lock/error status.
//
// Build option: define VGA_SYNC_DECODER_CHECKSUM_EN to add frame_checksum, a
// 16-bit wrapping sum of {red,green,blue} over the visible pixels of the
// previous frame. It is latched on each frame_start.
//
// FSM: SEARCH -> HTRACK on an hsync fall.
//      HTRACK -> LOCKED on a vsync fall.
//      HTRACK -> SEARCH on a horizontal mismatch, without counting an error.
//      LOCKED -> SEARCH on any violation, counting an error.
// state_dbg exposes the state encoding.
module vga_sync_decoder #(
  parameter int rows_total        = 525,
  parameter int rows_vsync        = 2,
  parameter int rows_back         = 33,
  parameter int rows_front        = 10,
  parameter int pixels_total      = 800,
  parameter int pixels_hsync      = 96,
  parameter int pixels_back       = 48,
  parameter int pixels_front      = 16,
  parameter int error_count_width = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           vga_hsync,
  input  logic                           vga_vsync,
  input  logic [3:0]                     vga_red,
  input  logic [3:0]                     vga_green,
  input  logic [3:0]                     vga_blue,
  input  logic                           error_clear,
  output logic [$clog2(pixels_total)-1:0] pixel_x,
  output logic [$clog2(rows_total)-1:0]  pixel_y,
  output logic                           pixel_valid,
  output logic [3:0]                     pixel_red,
  output logic [3:0]                     pixel_green,
  output logic [3:0]                     pixel_blue,
  output logic                           frame_start,
  output logic                           locked,
  output logic                           sync_error,
  output logic [error_count_width-1:0]   error_count,
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  output logic [15:0]                    frame_checksum,
`endif
  output logic [1:0]                     state_dbg
);

  localparam int HW   = $clog2(pixels_total);
  localparam int VW   = $clog2(rows_total);
  localparam int HVIS = pixels_total - pixels_hsync - pixels_back - pixels_front;
  localparam int VVIS = rows_total - rows_vsync - rows_back - rows_front;

  localparam logic [HW-1:0] H_LAST     = HW'(pixels_total - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(HVIS);
  localparam logic [HW-1:0] H_HS_START = HW'(HVIS + pixels_front);
  localparam logic [HW-1:0] H_HS_NEXT  = HW'(HVIS + pixels_front + 1);
  localparam logic [HW-1:0] H_HS_END   = HW'(HVIS + pixels_front + pixels_hsync);
  localparam logic [VW-1:0] V_LAST     = VW'(rows_total - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(VVIS);
  localparam logic [VW-1:0] V_VS_START = VW'(VVIS + rows_front);
  localparam logic [VW-1:0] V_VS_NEXT  = VW'(VVIS + rows_front + 1);
  localparam logic [VW-1:0] V_VS_END   = VW'(VVIS + rows_front + rows_vsync);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_HTRACK = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   hs_q, vs_q;
  logic [HW-1:0]          h_q, h_d, h_inc;
  logic [VW-1:0]          v_q, v_d, v_cur, v_inc;
  logic                   vfell_q, vfell_d;
  logic                   hs_fall, hs_rise, vs_fall, vs_rise;
  logic                   h_wrap, h_bad, v_bad, v_enter, viol;
  logic                   lock_d, valid_d, fs_d;

  logic [HW-1:0]          pixel_x_q;
  logic [VW-1:0]          pixel_y_q;
  logic [3:0]             pixel_red_q, pixel_green_q, pixel_blue_q;
  logic                   pixel_valid_q, frame_start_q, locked_q, sync_error_q;
  logic [error_count_width-1:0] error_count_q;

  // Edge detection, position prediction, timing checks and next-state decode.
  // h_q/v_q hold the predicted position of the sample on the inputs this cycle.
  always_comb begin
    hs_fall = hs_q & ~vga_hsync;
    hs_rise = ~hs_q & vga_hsync;
    vs_fall = vs_q & ~vga_vsync;
    vs_rise = ~vs_q & vga_vsync;

    h_wrap = (h_q == H_LAST);
    h_inc  = h_wrap ? '0 : h_q + 1'b1;
    // A vsync fall while tracking pins the current line to the vsync start line.
    v_cur  = (state_q == S_HTRACK && vs_fall) ? V_VS_START : v_q;
    v_inc  = h_wrap ? ((v_cur == V_LAST) ? '0 : v_cur + 1'b1) : v_cur;

    h_bad   = (hs_fall && h_q != H_HS_START) ||
              (hs_rise && h_q != H_HS_END) ||
              (h_q == H_HS_START && !hs_fall);
    v_enter = (h_q == '0) && (v_q == V_VS_NEXT);
    v_bad   = (vs_fall && v_q != V_VS_START) ||
              (vs_rise && v_q != V_VS_END) ||
              (v_enter && !vfell_q);

    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    vfell_d = vfell_q;
    viol    = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        // The falling sample itself sits at hs_start, so count on from there.
        if (hs_fall) begin
          state_d = S_HTRACK;
          h_d     = H_HS_NEXT;
        end
      end
      S_HTRACK: begin
        h_d = h_inc;
        v_d = v_inc;
        if (h_bad) begin
          state_d = S_SEARCH;
        end else if (vs_fall) begin
          state_d = S_LOCKED;
          vfell_d = 1'b1;
        end
      end
      S_LOCKED: begin
        h_d = h_inc;
        v_d = v_inc;
        if (vs_fall) vfell_d = 1'b1;
        if (v_enter) vfell_d = 1'b0;
        if (h_bad || v_bad) begin
          viol    = 1'b1;
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_SEARCH;
    endcase

    lock_d  = (state_d == S_LOCKED);
    valid_d = lock_d && (h_q < H_VIS) && (v_cur < V_VIS);
    fs_d    = lock_d && (h_q == '0) && (v_cur == '0);
  end

  // State, counters, input register stage and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_q           <= '0;
      v_q           <= '0;
      vfell_q       <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_red_q   <= '0;
      pixel_green_q <= '0;
      pixel_blue_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_error_q  <= 1'b0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hs_q          <= vga_hsync;
      vs_q          <= vga_vsync;
      h_q           <= h_d;
      v_q           <= v_d;
      vfell_q       <= vfell_d;
      pixel_x_q     <= h_q;
      pixel_y_q     <= v_cur;
      pixel_red_q   <= vga_red;
      pixel_green_q <= vga_green;
      pixel_blue_q  <= vga_blue;
      pixel_valid_q <= valid_d;
      frame_start_q <= fs_d;
      locked_q      <= lock_d;
      // A clear wins over a violation in the same cycle.
      if (error_clear) begin
        sync_error_q  <= 1'b0;
        error_count_q <= '0;
      end else if (viol) begin
        sync_error_q <= 1'b1;
        if (error_count_q != '1) error_count_q <= error_count_q + 1'b1;
      end
    end
  end

`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] acc_q, checksum_q;

  // Per-frame colour sum; the frame_start sample opens the new sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else if (fs_d) begin
      checksum_q <= acc_q;
      acc_q      <= {4'b0, vga_red, vga_green, vga_blue};
    end else if (valid_d) begin
      acc_q      <= acc_q + {4'b0, vga_red, vga_green, vga_blue};
    end
  end

  assign frame_checksum = checksum_q;
`endif

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_red   = pixel_red_q;
  assign pixel_green = pixel_green_q;
  assign pixel_blue  = pixel_blue_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign sync_error  = sync_error_q;
  assign error_count = error_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with shrunken timing.
//   Line: 20 clocks: visible 0..13, front 14..15, hsync 16..17, back 18..19.
//   Frame: 12 lines: visible 0..6, front 7, vsync 8..9, back 10..11.
//   One frame = 240 clocks, with 98 visible pixels.
// error_count is 4 bits wide, so it saturates at 15.
module tb_vga_sync_decoder;

  localparam int PT = 20, RT = 12;
  localparam int HS_START = 16, HS_END = 18, VS_START = 8, VS_END = 10;
  localparam int HVIS = 14, VVIS = 7, FRAME = 240, VIS = 98;

  logic       clock, reset, vga_hsync, vga_vsync, error_clear;
  logic [3:0] vga_red, vga_green, vga_blue;
  logic [4:0] pixel_x;
  logic [3:0] pixel_y;
  logic       pixel_valid, frame_start, locked, sync_error;
  logic [3:0] pixel_red, pixel_green, pixel_blue, error_count;
  logic [1:0] state_dbg;
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
  logic [15:0] frame_checksum;
`endif

  int n_checks, n_errors;
  int gx, gy, lx, ly;
  bit hs_late, clr_with_late, vs_drop, all_one, ov_en;
  int ov_x, ov_y;
  logic [11:0] ov_rgb;

  vga_sync_decoder #(
    .rows_total(RT), .rows_vsync(2), .rows_back(2), .rows_front(1),
    .pixels_total(PT), .pixels_hsync(2), .pixels_back(2), .pixels_front(2),
    .error_count_width(4)
  ) dut (
    .clock(clock), .reset(reset),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .error_clear(error_clear),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
    .frame_start(frame_start), .locked(locked),
    .sync_error(sync_error), .error_count(error_count),
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    .frame_checksum(frame_checksum),
`endif
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] pat_rgb(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[3:0], yv[3:0], 4'h5};
  endfunction

  // Drive one generator sample (gx,gy).
  // Returns #1 after the edge that registered it, with lx/ly naming that sample.
  task automatic tick();
    logic hs, vs;
    logic [11:0] rgb;
    hs = !(gx >= HS_START && gx < HS_END);
    vs = !(gy >= VS_START && gy < VS_END);
    error_clear = 1'b0;
    if (hs_late && gx == HS_START) begin
      hs = 1'b1;
      error_clear = clr_with_late;
      hs_late = 1'b0;
    end
    if (vs_drop) vs = 1'b1;
    if (all_one) rgb = 12'h001;
    else if (ov_en && gx == ov_x && gy == ov_y) rgb = ov_rgb;
    else rgb = pat_rgb(gx, gy);
    vga_hsync = hs;
    vga_vsync = vs;
    {vga_red, vga_green, vga_blue} = rgb;
    @(posedge clock);
    #1;
    lx = gx;
    ly = gy;
    if (gx == PT - 1) begin
      gx = 0;
      gy = (gy == RT - 1) ? 0 : gy + 1;
    end else begin
      gx = gx + 1;
    end
  endtask

  task automatic run_to(input int x, input int y);
    for (int i = 0; i < FRAME + 2 && !(gx == x && gy == y); i++) tick();
  endtask

  task automatic wait_locked(output bit ok);
    for (int i = 0; i < 2 * FRAME && locked !== 1'b1; i++) tick();
    ok = (locked === 1'b1);
  endtask

  // Delay the hsync fall of the next line by one clock; optional same-cycle clear.
  task automatic inject_hs(input bit with_clr);
    bit done;
    hs_late = 1'b1;
    clr_with_late = with_clr;
    done = 0;
    for (int i = 0; i < PT + 1 && !done; i++) begin
      tick();
      if (lx == HS_START) done = 1;
    end
    hs_late = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (pixel_x !== 5'd0 || pixel_y !== 4'd0) begin n_errors++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", pixel_x, pixel_y); end
    n_checks++; if ({pixel_red, pixel_green, pixel_blue} !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h expected 000", {pixel_red, pixel_green, pixel_blue}); end
    n_checks++; if ({pixel_valid, frame_start, locked, sync_error} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", {pixel_valid, frame_start, locked, sync_error}); end
    n_checks++; if (error_count !== 4'd0) begin n_errors++; $display("FAIL reset_ecount: got %0d expected 0", error_count); end
    reset = 1'b1;
    gx = 0;
    gy = 0;
  endtask

  task automatic test_lock();
    bit ok, found;
    int vcnt, fcnt;
    wait_locked(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL lock_time: got locked=%b expected 1 within 2 frames", locked); end
    found = 0;
    for (int i = 0; i < FRAME + 1 && !found; i++) begin
      tick();
      if (frame_start === 1'b1) found = 1;
    end
    n_checks++; if (!found || pixel_x !== 5'd0 || pixel_y !== 4'd0) begin n_errors++; $display("FAIL first_fs: got found=%0d at %0d,%0d expected 1 at 0,0", found, pixel_x, pixel_y); end
    vcnt = (pixel_valid === 1'b1) ? 1 : 0;
    fcnt = 0;
    for (int i = 1; i < FRAME; i++) begin
      tick();
      if (pixel_valid === 1'b1) vcnt++;
      if (frame_start === 1'b1) fcnt++;
      n_checks++;
      if (pixel_valid !== (lx < HVIS && ly < VVIS) || pixel_x !== 5'(lx) || pixel_y !== 4'(ly) ||
          {pixel_red, pixel_green, pixel_blue} !== pat_rgb(lx, ly)) begin
        n_errors++;
        $display("FAIL frame_sample: got v=%b (%0d,%0d) rgb=%h expected v=%b (%0d,%0d) rgb=%h",
                 pixel_valid, pixel_x, pixel_y, {pixel_red, pixel_green, pixel_blue},
                 (lx < HVIS && ly < VVIS), lx, ly, pat_rgb(lx, ly));
      end
    end
    n_checks++; if (vcnt != VIS) begin n_errors++; $display("FAIL valid_count: got %0d expected %0d", vcnt, VIS); end
    n_checks++; if (fcnt != 0) begin n_errors++; $display("FAIL fs_extra: got %0d expected 0", fcnt); end
    tick();
    n_checks++; if (frame_start !== 1'b1) begin n_errors++; $display("FAIL fs_period: got %b expected 1", frame_start); end
  endtask

  task automatic test_last_pixel();
    bit found;
    ov_en = 1;
    ov_x = HVIS - 1;
    ov_y = VVIS - 1;
    ov_rgb = 12'hABC;
    run_to(HVIS - 1, VVIS - 1);
    tick();
    ov_en = 0;
    n_checks++; if (pixel_x !== 5'd13 || pixel_y !== 4'd6 || pixel_valid !== 1'b1) begin n_errors++; $display("FAIL last_xy: got %0d,%0d v=%b expected 13,6 v=1", pixel_x, pixel_y, pixel_valid); end
    n_checks++; if ({pixel_red, pixel_green, pixel_blue} !== 12'hABC) begin n_errors++; $display("FAIL last_rgb: got %h expected abc", {pixel_red, pixel_green, pixel_blue}); end
    found = 0;
    for (int i = 0; i < FRAME && !found; i++) begin
      tick();
      if (pixel_valid === 1'b1) found = 1;
    end
    n_checks++; if (!found || pixel_x !== 5'd0 || pixel_y !== 4'd0 || frame_start !== 1'b1) begin n_errors++; $display("FAIL next_valid: got %0d,%0d fs=%b expected 0,0 fs=1", pixel_x, pixel_y, frame_start); end
  endtask

  task automatic test_hs_shift();
    bit ok;
    n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL pre_shift_lock: got %b expected 1", locked); end
    inject_hs(0);
    n_checks++; if ({locked, sync_error} !== 2'b01 || error_count !== 4'd1) begin n_errors++; $display("FAIL hs_shift: got lock=%b err=%b cnt=%0d expected 0 1 1", locked, sync_error, error_count); end
    wait_locked(ok);
    n_checks++; if (!ok || error_count !== 4'd1) begin n_errors++; $display("FAIL hs_relock: got lock=%b cnt=%0d expected 1 1", locked, error_count); end
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 14; i++) begin
      wait_locked(ok);
      inject_hs(0);
    end
    n_checks++; if (error_count !== 4'd15) begin n_errors++; $display("FAIL count_15: got %0d expected 15", error_count); end
    wait_locked(ok);
    inject_hs(0);
    n_checks++; if (error_count !== 4'd15 || sync_error !== 1'b1) begin n_errors++; $display("FAIL count_sat: got %0d err=%b expected 15 1", error_count, sync_error); end
    wait_locked(ok);
    inject_hs(1);
    n_checks++; if (error_count !== 4'd0 || sync_error !== 1'b0 || locked !== 1'b0) begin n_errors++; $display("FAIL clear_prio: got cnt=%0d err=%b lock=%b expected 0 0 0", error_count, sync_error, locked); end
  endtask

  task automatic test_vs_drop();
    bit ok, dropped;
    wait_locked(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL vs_prelock: got %b expected 1", locked); end
    run_to(0, 0);
    vs_drop = 1;
    dropped = 0;
    for (int i = 0; i < FRAME && !dropped; i++) begin
      tick();
      if (locked === 1'b0) dropped = 1;
    end
    n_checks++; if (!dropped || lx != 0 || ly != VS_START + 1) begin n_errors++; $display("FAIL vs_drop_pos: got drop=%0d at %0d,%0d expected 1 at 0,%0d", dropped, lx, ly, VS_START + 1); end
    n_checks++; if (error_count !== 4'd1 || sync_error !== 1'b1) begin n_errors++; $display("FAIL vs_drop_cnt: got %0d err=%b expected 1 1", error_count, sync_error); end
    run_to(0, 0);
    vs_drop = 0;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    wait_locked(ok);
    run_to(0, 3);
    reset = 1'b0;
    #1;
    n_checks++; if (pixel_x !== 5'd0 || pixel_y !== 4'd0) begin n_errors++; $display("FAIL mid_reset_xy: got %0d,%0d expected 0,0", pixel_x, pixel_y); end
    n_checks++; if ({pixel_red, pixel_green, pixel_blue} !== 12'h000) begin n_errors++; $display("FAIL mid_reset_rgb: got %h expected 000", {pixel_red, pixel_green, pixel_blue}); end
    n_checks++; if ({pixel_valid, frame_start, locked, sync_error} !== 4'b0 || error_count !== 4'd0) begin n_errors++; $display("FAIL mid_reset_flags: got %b cnt=%0d expected 0000 0", {pixel_valid, frame_start, locked, sync_error}, error_count); end
    tick();
    tick();
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    all_one = 1;
`endif
    reset = 1'b1;
    wait_locked(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL mid_relock: got %b expected 1", locked); end
`ifdef VGA_SYNC_DECODER_CHECKSUM_EN
    begin
      bit f1, f2;
      f1 = 0;
      f2 = 0;
      for (int i = 0; i < 2 * FRAME && !f1; i++) begin tick(); if (frame_start === 1'b1) f1 = 1; end
      for (int i = 0; i < FRAME + 1 && !f2; i++) begin tick(); if (frame_start === 1'b1) f2 = 1; end
      n_checks++; if (!f2 || frame_checksum !== 16'd98) begin n_errors++; $display("FAIL checksum: got %0d expected 98", frame_checksum); end
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    gx = 0; gy = 0; lx = 0; ly = 0;
    hs_late = 0; clr_with_late = 0; vs_drop = 0; all_one = 0; ov_en = 0;
    ov_x = 0; ov_y = 0; ov_rgb = 12'h000;
    reset = 1'b0;
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    vga_red = 4'h0; vga_green = 4'h0; vga_blue = 4'h0;
    error_clear = 1'b0;
    test_reset();
    test_lock();
    test_last_pixel();
    test_hs_shift();
    test_saturation();
    test_vs_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
